// File: rtl/rtc_rw_if.sv
// Handshake and RTC bus signals of the read/write sequencer, bundled for port connection.
// The master side drives the transaction request; the slave side drives the RTC strobes and flags.
interface rtc_rw_if;
   logic i_start;
   logic i_write;
   logic o_csN;
   logic o_rdN;
   logic o_wrN;
   logic o_ad;
   logic o_benvAdress;
   logic o_benvData;
   logic o_bresData;
   logic o_busy;
   logic o_done;

   modport master (
      output i_start, i_write,
      input  o_csN, o_rdN, o_wrN, o_ad, o_benvAdress, o_benvData,
             o_bresData, o_busy, o_done
   );

   modport slave (
      input  i_start, i_write,
      output o_csN, o_rdN, o_wrN, o_ad, o_benvAdress, o_benvData,
             o_bresData, o_busy, o_done
   );
endinterface

// File: rtl/rtc_rw_fsm.sv
// RTC bus sequencer: address strobe, gap, then a read or write data strobe, all timed in clock cycles.
// Outputs are decoded from the next state and registered so they line up with the state they describe.
module rtc_rw_fsm #(
   parameter int T_PULSE = 8,
   parameter int T_HOLD  = 2,
   parameter int T_GAP   = 4
) (
   input logic     clk,
   input logic     rst,
   rtc_rw_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_A_PULSE, ST_A_HOLD, ST_GAP, ST_D_PULSE, ST_D_HOLD, ST_FIN
   } state_t;

   localparam logic [7:0] LP_PULSE_LOAD = 8'(T_PULSE - 1);
   localparam logic [7:0] LP_HOLD_LOAD  = 8'(T_HOLD - 1);
   localparam logic [7:0] LP_GAP_LOAD   = 8'(T_GAP - 1);

   state_t     r_state;
   state_t     w_nextState;
   logic [7:0] r_count;
   logic [7:0] w_nextCount;
   logic       r_write;
   logic       w_nextWrite;
   logic       r_armed;

   logic r_csN, r_rdN, r_wrN, r_ad, r_benvAdress, r_benvData, r_bresData, r_busy, r_done;
   logic w_csN, w_rdN, w_wrN, w_ad, w_benvAdress, w_benvData, w_bresData, w_busy, w_done;

   // r_armed stays low for the first edge after reset so a START held across release is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_count <= 8'd0;
         r_write <= 1'b0;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_count <= w_nextCount;
         r_write <= w_nextWrite;
         r_armed <= 1'b1;
      end
   end

   // Each timed state loads N-1 on entry and leaves when the counter reaches zero.
   always_comb begin
      w_nextState = r_state;
      w_nextCount = r_count;
      w_nextWrite = r_write;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_start && r_armed) begin
               w_nextState = ST_A_PULSE;
               w_nextCount = LP_PULSE_LOAD;
               w_nextWrite = bus.i_write;
            end
         end
         ST_A_PULSE: begin
            if (r_count == 8'd0) begin
               w_nextState = ST_A_HOLD;
               w_nextCount = LP_HOLD_LOAD;
            end else begin
               w_nextCount = r_count - 8'd1;
            end
         end
         ST_A_HOLD: begin
            if (r_count == 8'd0) begin
               w_nextState = ST_GAP;
               w_nextCount = LP_GAP_LOAD;
            end else begin
               w_nextCount = r_count - 8'd1;
            end
         end
         ST_GAP: begin
            if (r_count == 8'd0) begin
               w_nextState = ST_D_PULSE;
               w_nextCount = LP_PULSE_LOAD;
            end else begin
               w_nextCount = r_count - 8'd1;
            end
         end
         ST_D_PULSE: begin
            if (r_count == 8'd0) begin
               w_nextState = ST_D_HOLD;
               w_nextCount = LP_HOLD_LOAD;
            end else begin
               w_nextCount = r_count - 8'd1;
            end
         end
         ST_D_HOLD: begin
            if (r_count == 8'd0) begin
               w_nextState = ST_FIN;
               w_nextCount = 8'd0;
            end else begin
               w_nextCount = r_count - 8'd1;
            end
         end
         ST_FIN: begin
            w_nextState = ST_IDLE;
            w_nextCount = 8'd0;
         end
         default: begin
            w_nextState = ST_IDLE;
            w_nextCount = 8'd0;
         end
      endcase
   end

   // Read capture strobe fires in the final D_PULSE cycle, when the next counter value is zero.
   always_comb begin
      w_csN        = 1'b1;
      w_rdN        = 1'b1;
      w_wrN        = 1'b1;
      w_ad         = 1'b0;
      w_benvAdress = 1'b0;
      w_benvData   = 1'b0;
      w_bresData   = 1'b0;
      w_busy       = (w_nextState != ST_IDLE);
      w_done       = 1'b0;
      case (w_nextState)
         ST_A_PULSE: begin
            w_csN        = 1'b0;
            w_wrN        = 1'b0;
            w_benvAdress = 1'b1;
         end
         ST_A_HOLD: begin
            w_csN        = 1'b0;
            w_benvAdress = 1'b1;
         end
         ST_GAP: begin
            w_ad = 1'b1;
         end
         ST_D_PULSE: begin
            w_csN = 1'b0;
            w_ad  = 1'b1;
            if (w_nextWrite) begin
               w_wrN      = 1'b0;
               w_benvData = 1'b1;
            end else begin
               w_rdN      = 1'b0;
               w_bresData = (w_nextCount == 8'd0);
            end
         end
         ST_D_HOLD: begin
            w_csN      = 1'b0;
            w_ad       = 1'b1;
            w_benvData = w_nextWrite;
         end
         ST_FIN: begin
            w_done = 1'b1;
         end
         default: begin
            w_busy = 1'b0;
         end
      endcase
   end

   // Output register bank; reset values describe a released, idle bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_csN        <= 1'b1;
         r_rdN        <= 1'b1;
         r_wrN        <= 1'b1;
         r_ad         <= 1'b0;
         r_benvAdress <= 1'b0;
         r_benvData   <= 1'b0;
         r_bresData   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_csN        <= w_csN;
         r_rdN        <= w_rdN;
         r_wrN        <= w_wrN;
         r_ad         <= w_ad;
         r_benvAdress <= w_benvAdress;
         r_benvData   <= w_benvData;
         r_bresData   <= w_bresData;
         r_busy       <= w_busy;
         r_done       <= w_done;
      end
   end

   assign bus.o_csN        = r_csN;
   assign bus.o_rdN        = r_rdN;
   assign bus.o_wrN        = r_wrN;
   assign bus.o_ad         = r_ad;
   assign bus.o_benvAdress = r_benvAdress;
   assign bus.o_benvData   = r_benvData;
   assign bus.o_bresData   = r_bresData;
   assign bus.o_busy       = r_busy;
   assign bus.o_done       = r_done;

endmodule

// File: doc/rtc_rw_fsm.md
RTC_RW_FSM -- requirements
Module: rtc_rw_fsm

Interface
REQ-001 Parameter T_PULSE, default 8, CS/strobe low time in CLK cycles, legal 1..255.
REQ-002 Parameter T_HOLD, default 2, post-strobe bus hold time in cycles, legal 1..255.
REQ-003 Parameter T_GAP, default 4, CS-high gap between address and data phases, legal 1..255.
REQ-004 CLK  in  1  single system clock; all state changes on rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 START  in  1  transaction request, sampled only in IDLE.
REQ-007 WRITE  in  1  1 = write transaction, 0 = read; captured with START.
REQ-008 CS_n, RD_n, WR_n  out  1 each  RTC chip-select / read / write strobes, active-low.
REQ-009 AD  out  1  RTC address/data select: 0 = address phase, 1 = data phase.
REQ-010 BEnv_Adress  out  1  bus-drive flag, address on shared bus.
REQ-011 BEnv_Data  out  1  bus-drive flag, write data on shared bus.
REQ-012 BRes_Data  out  1  one-cycle capture strobe for read data.
REQ-013 BUSY  out  1  high in every state except IDLE.
REQ-014 DONE  out  1  one-cycle pulse, transaction complete.

Function
REQ-015 All outputs SHALL be registered; no combinational path from START/WRITE to any output.
REQ-016 States SHALL be IDLE, A_PULSE, A_HOLD, GAP, D_PULSE, D_HOLD, FIN.
REQ-017 IDLE: CS_n=RD_n=WR_n=1, AD=0, all flags 0; START=1 SHALL latch WRITE and enter A_PULSE next cycle.
REQ-018 START asserted outside IDLE (including FIN) SHALL be ignored, not queued.
REQ-019 An 8-bit down-counter SHALL time each timed state; load N-1 on entry, leave when 0, so state lasts exactly N cycles.
REQ-020 A_PULSE (T_PULSE cycles): CS_n=0, WR_n=0, AD=0, BEnv_Adress=1.
REQ-021 A_HOLD (T_HOLD cycles): CS_n=0, WR_n=1, AD=0, BEnv_Adress=1.
REQ-022 GAP (T_GAP cycles): CS_n=1, strobes high, AD=1, all flags 0 (shared bus released).
REQ-023 D_PULSE write (T_PULSE): CS_n=0, WR_n=0, RD_n=1, AD=1, BEnv_Data=1.
REQ-024 D_PULSE read (T_PULSE): CS_n=0, RD_n=0, WR_n=1, AD=1, BEnv_Data=0; BRes_Data=1 only in its last cycle.
REQ-025 D_HOLD (T_HOLD): CS_n=0, strobes high, AD=1; BEnv_Data stays 1 for write, 0 for read.
REQ-026 FIN (1 cycle): DONE=1, CS_n=1, strobes high, flags 0; then IDLE.
REQ-027 BEnv_Adress and BEnv_Data SHALL never be 1 together; RD_n and WR_n SHALL never be 0 together.
REQ-028 BRes_Data SHALL pulse exactly once per read and never during a write.
REQ-029 Total START-sample to DONE latency SHALL be 2*T_PULSE+2*T_HOLD+T_GAP+1 cycles (defaults: 25).
REQ-030 Latched WRITE SHALL not change mid-transaction regardless of WRITE input.

Reset
REQ-031 RST=1 SHALL immediately force IDLE, counter 0, CS_n=RD_n=WR_n=1, AD=0, BEnv_Adress=BEnv_Data=BRes_Data=BUSY=DONE=0.
REQ-032 RST mid-transaction SHALL abort with no DONE; first START after RST release SHALL begin a fresh transaction.
REQ-033 START coincident with the RST-release edge SHALL be ignored.

Verification
REQ-034 Reset: assert RST with START=1 -> all outputs at REQ-031 values, BUSY=0 throughout.
REQ-035 Default write: START=1,WRITE=1 at cycle 0 -> WR_n low cycles 1-8, AD low 1-10, CS_n high 11-14, WR_n low 15-22, BEnv_Data 15-24, DONE at 25.
REQ-036 Default read: START=1,WRITE=0 -> RD_n low cycles 15-22, BRes_Data only at 22, BEnv_Data never 1, DONE at 25.
REQ-037 START pulsed at cycles 5 and 25 -> both ignored; single DONE at 25; next START at 26 accepted.
REQ-038 RST pulse at cycle 17 of write -> outputs idle same cycle, no DONE; restart completes 25 cycles after its START.
REQ-039 T_PULSE=1,T_HOLD=1,T_GAP=1 read -> DONE 6 cycles after START, BRes_Data on the single RD_n-low cycle.
